// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/DIV sequencer: shift-add multiply and restoring divide into HI/LO.
// Define MD_SIGNED_EN for two's complement operands; otherwise unsigned (multu/divu).
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW      = $clog2(WIDTH) + 1;
    localparam logic [3:0]    OP_MULT = 4'b1000;
    localparam logic [3:0]    OP_DIV  = 4'b1001;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        counter_q, counter_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       remShift;
    logic [WIDTH-1:0]     remNext;
    logic [WIDTH-1:0]     quoNext;
    logic [WIDTH-1:0]     magA, magB;
    logic [2*WIDTH-1:0]   mulFinal;
    logic [WIDTH-1:0]     divHi, divLo;

    // One iteration of each algorithm, evaluated from the current registers.
    assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mulNext  = {mulSum, prod_q[WIDTH-1:1]};
    assign remShift = {rem_q, quo_q[WIDTH-1]};

    always_comb begin
        remNext = remShift[WIDTH-1:0];
        quoNext = {quo_q[WIDTH-2:0], 1'b0};
        if (remShift >= {1'b0, opnd_q}) begin
            remNext = remShift[WIDTH-1:0] - opnd_q;
            quoNext = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

`ifdef MD_SIGNED_EN
    logic negRes_q, negRes_d;
    logic negRem_q, negRem_d;

    assign magA     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign magB     = operand_b[WIDTH-1] ? -operand_b : operand_b;
    assign mulFinal = negRes_q ? -mulNext : mulNext;
    assign divLo    = negRes_q ? -quoNext : quoNext;
    assign divHi    = negRem_q ? -remNext : remNext;
`else
    assign magA     = operand_a;
    assign magB     = operand_b;
    assign mulFinal = mulNext;
    assign divLo    = quoNext;
    assign divHi    = remNext;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
`ifdef MD_SIGNED_EN
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
`ifdef MD_SIGNED_EN
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = 1'b0;
`ifdef MD_SIGNED_EN
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && md_op == OP_MULT) begin
                    state_d   = MUL;
                    counter_d = '0;
                    prod_d    = {{WIDTH{1'b0}}, magB};
                    opnd_d    = magA;
`ifdef MD_SIGNED_EN
                    negRes_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
`endif
                end else if (start && md_op == OP_DIV) begin
                    if (operand_b == '0) begin
                        // Divide by zero skips iteration and reports straight away.
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        lo_d    = '1;
                        hi_d    = operand_a;
                    end else begin
                        state_d   = DIV;
                        counter_d = '0;
                        rem_d     = '0;
                        quo_d     = magA;
                        opnd_d    = magB;
`ifdef MD_SIGNED_EN
                        negRes_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        negRem_d  = operand_a[WIDTH-1];
`endif
                    end
                end
            end
            MUL: begin
                prod_d    = mulNext;
                counter_d = counter_q + CW'(1);
                if (counter_q == LAST) begin
                    state_d      = DONE;
                    counter_d    = '0;
                    {hi_d, lo_d} = mulFinal;
                end
            end
            DIV: begin
                rem_d     = remNext;
                quo_d     = quoNext;
                counter_d = counter_q + CW'(1);
                if (counter_q == LAST) begin
                    state_d   = DONE;
                    counter_d = '0;
                    hi_d      = divHi;
                    lo_d      = divLo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed self-checking bench for mult_div_sequencer with hand-computed HI/LO and timing.
module tb_mult_div_sequencer;

    localparam int         WIDTH   = 32;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checkCount = 0;
    int errorCount = 0;
    int doneCyc;
    int busyCnt;

    mult_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .md_op      (md_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1 after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start     = 1'b1;
        md_op     = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
    endtask

    task automatic waitDone(input int firstCyc, output int cyc, output int nBusy);
        cyc   = firstCyc;
        nBusy = 0;
        while (!done && cyc < 200) begin
            if (busy) nBusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expHi,
                         input logic [WIDTH-1:0] expLo, input logic expDbz, input int expCyc);
        int c, nb;
        applyStimulus(op, a, b);
        waitDone(1, c, nb);
        checkOutput({tag, " doneCycle"}, 64'(c), 64'(expCyc));
        checkOutput({tag, " busyCycles"}, 64'(nb), 64'(expCyc - 1));
        checkOutput({tag, " busyAtDone"}, 64'(busy), 64'(0));
        checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
        checkOutput({tag, " divByZero"}, 64'(div_by_zero), 64'(expDbz));
        @(negedge clk);
        checkOutput({tag, " donePulse"}, 64'(done), 64'(0));
        checkOutput({tag, " dbzPulse"}, 64'(div_by_zero), 64'(0));
        checkOutput({tag, " loHold"}, 64'(lo), 64'(expLo));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        md_op     = 4'b0000;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset dbz", 64'(div_by_zero), 64'(0));
        checkOutput("reset hi", 64'(hi), 64'(0));
        checkOutput("reset lo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Unsupported control code must be ignored.
        applyStimulus(4'b0011, 32'd7, 32'd6);
        checkOutput("badOp busy", 64'(busy), 64'(0));
        checkOutput("badOp done", 64'(done), 64'(0));

        runOp("mult7x6", OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33);
`ifdef MD_SIGNED_EN
        runOp("multNeg1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33);
`else
        runOp("multMax", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 33);
`endif

        // Reset during iteration 10 aborts and clears HI/LO.
        applyStimulus(OP_MULT, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        checkOutput("abort busyBefore", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort done", 64'(done), 64'(0));
        checkOutput("abort hi", 64'(hi), 64'(0));
        checkOutput("abort lo", 64'(lo), 64'(0));
        runOp("mult2x5", OP_MULT, 32'd2, 32'd5, 32'd0, 32'd10, 1'b0, 33);

        runOp("div100by7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
`ifdef MD_SIGNED_EN
        runOp("divNeg100by7", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33);
        runOp("divMinByNeg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
`else
        runOp("divBig", OP_DIV, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 33);
`endif
        runOp("div5by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);

        // Start during iteration is ignored; start in the done cycle is accepted.
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        checkOutput("b2b busyCycle5", 64'(busy), 64'(1));
        start     = 1'b1;
        md_op     = OP_MULT;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        waitDone(6, doneCyc, busyCnt);
        checkOutput("b2b first doneCycle", 64'(doneCyc), 64'(33));
        checkOutput("b2b first lo", 64'(lo), 64'(12));
        applyStimulus(OP_DIV, 32'd9, 32'd3);
        checkOutput("b2b second busy", 64'(busy), 64'(1));
        checkOutput("b2b second done", 64'(done), 64'(0));
        waitDone(1, doneCyc, busyCnt);
        checkOutput("b2b second doneCycle", 64'(doneCyc), 64'(33));
        checkOutput("b2b second lo", 64'(lo), 64'(3));
        checkOutput("b2b second hi", 64'(hi), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
